// File: rtl/switch_logic_sequencer_if.sv
// Switch/LED bundle for switch_logic_sequencer: raw switches in, pair-logic LEDs and mode out.
interface switch_logic_sequencer_if;
  logic [3:0] i_Switch;
  logic [3:0] o_LED;
  logic [1:0] o_Mode;

  modport master (output i_Switch, input o_LED, input o_Mode);
  modport slave  (input i_Switch, output o_LED, output o_Mode);
endinterface

// File: rtl/switch_logic_sequencer.sv
// Debounced 4-switch pair-logic LED driver with a chord-stepped AND/OR/XOR/NAND mode.
// Define SEQ_AUTO_CYCLE_EN to also step the mode every AUTO_PERIOD cycles.
module switch_logic_sequencer #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int AUTO_PERIOD    = 25000000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  switch_logic_sequencer_if.slave bus
);
  localparam int DCW = $clog2(DEBOUNCE_LIMIT);

  typedef enum logic [1:0] {MODE_AND, MODE_OR, MODE_XOR, MODE_NAND} mode_e;

  logic [3:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]          deb_q, deb_d, prev_q, prev_d;
  logic [3:0][DCW-1:0] cnt_q, cnt_d;
  logic [3:0]          led_q, led_d;
  logic [3:0]          lhs, rhs;
  mode_e               mode_q, mode_d;
  logic                chord, step;

  always_comb begin
    sync1_d = bus.i_Switch;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    prev_d  = deb_q;
    cnt_d   = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DCW'(DEBOUNCE_LIMIT - 1)) deb_d[i] = sync2_q[i];
        else                                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Rising edge into the all-on chord only; holding it does not repeat the step.
  assign chord = (deb_q == 4'b1111) && (prev_q != 4'b1111);

`ifdef SEQ_AUTO_CYCLE_EN
  localparam int ACW = $clog2(AUTO_PERIOD);
  logic [ACW-1:0] auto_q, auto_d;
  logic           expire;

  assign expire = (auto_q == ACW'(AUTO_PERIOD - 1));
  assign step   = chord | expire;
  assign auto_d = step ? '0 : auto_q + 1'b1;
`else
  assign step = chord;
`endif

  always_comb begin
    mode_d = mode_q;
    if (step) begin
      case (mode_q)
        MODE_AND:  mode_d = MODE_OR;
        MODE_OR:   mode_d = MODE_XOR;
        MODE_XOR:  mode_d = MODE_NAND;
        MODE_NAND: mode_d = MODE_AND;
        default:   mode_d = MODE_AND;
      endcase
    end
  end

  // LED n pairs left switch n/2 with right switch 2+n%2.
  assign lhs = {deb_q[1], deb_q[1], deb_q[0], deb_q[0]};
  assign rhs = {deb_q[3], deb_q[2], deb_q[3], deb_q[2]};

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_AND:  led_d = lhs & rhs;
      MODE_OR:   led_d = lhs | rhs;
      MODE_XOR:  led_d = lhs ^ rhs;
      MODE_NAND: led_d = ~(lhs & rhs);
      default:   led_d = '0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
      mode_q  <= MODE_AND;
`ifdef SEQ_AUTO_CYCLE_EN
      auto_q  <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      mode_q  <= mode_d;
`ifdef SEQ_AUTO_CYCLE_EN
      auto_q  <= auto_d;
`endif
    end
  end

  assign bus.o_LED  = led_q;
  assign bus.o_Mode = mode_q;
endmodule

// File: tb/tb_switch_logic_sequencer.sv
// Bench for switch_logic_sequencer: directed scenarios plus random switch traffic vs a window-based model.
module tb_switch_logic_sequencer;
  localparam int LIMIT  = 4;
  localparam int PERIOD = 10;

  logic i_Clk = 1'b0;
  logic i_Rst_L;
  int   n_tests = 0;
  int   n_fail  = 0;

  switch_logic_sequencer_if bus ();

  switch_logic_sequencer #(.DEBOUNCE_LIMIT(LIMIT), .AUTO_PERIOD(PERIOD)) dut (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .bus     (bus)
  );

  always #5 i_Clk = ~i_Clk;

  // Reference model state
  logic [3:0] m_hist[$];
  logic [3:0] m_win[$];
  logic [3:0] m_deb, m_prev, m_led;
  int         m_mode, m_t;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] pair_logic(input int mode, input logic [3:0] d);
    logic [3:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      int l, rr;
      l  = int'(d[j / 2]);
      rr = int'(d[2 + (j % 2)]);
      case (mode)
        0: r[j] = (l + rr == 2);
        1: r[j] = (l + rr >= 1);
        2: r[j] = (l + rr == 1);
        default: r[j] = (l + rr != 2);
      endcase
    end
    return r;
  endfunction

  task automatic model_edge(input logic [3:0] sw, input logic rst_l);
    logic [3:0] seen, old_deb, old_prev;
    int         old_mode;
    bit         chord, expire;
    if (!rst_l) begin
      m_hist.delete(); m_win.delete();
      m_deb = '0; m_prev = '0; m_led = '0; m_mode = 0; m_t = 0;
      return;
    end
    // debouncer sees the raw value sampled two edges earlier
    seen = (m_hist.size() >= 2) ? m_hist[0] : 4'b0000;
    m_hist.push_back(sw);
    if (m_hist.size() > 2) void'(m_hist.pop_front());
    m_win.push_back(seen);
    if (m_win.size() > LIMIT) void'(m_win.pop_front());

    old_deb  = m_deb;
    old_prev = m_prev;
    old_mode = m_mode;
    m_led    = pair_logic(old_mode, old_deb);
    chord    = (old_deb == 4'b1111) && (old_prev != 4'b1111);
`ifdef SEQ_AUTO_CYCLE_EN
    expire   = (m_t == PERIOD - 1);
`else
    expire   = 1'b0;
`endif
    if (chord || expire) begin
      m_mode = (m_mode + 1) % 4;
      m_t    = 0;
    end else begin
      m_t++;
    end
    m_prev = old_deb;
    // a bit flips once the last LIMIT synced samples all disagree with it
    if (m_win.size() == LIMIT) begin
      for (int b = 0; b < 4; b++) begin
        bit all_diff;
        all_diff = 1'b1;
        foreach (m_win[k]) if (m_win[k][b] == old_deb[b]) all_diff = 1'b0;
        if (all_diff) m_deb[b] = ~old_deb[b];
      end
    end
  endtask

  // Drive at negedge, advance model at posedge, check at next negedge.
  task automatic cyc(input logic [3:0] sw, input logic rst_l);
    bus.i_Switch = sw;
    i_Rst_L      = rst_l;
    @(posedge i_Clk);
    model_edge(sw, rst_l);
    @(negedge i_Clk);
    chk("led", {4'b0, bus.o_LED}, {4'b0, m_led});
    chk("mode", {6'b0, bus.o_Mode}, 8'(m_mode));
  endtask

  task automatic hold(input logic [3:0] sw, input int n);
    for (int k = 0; k < n; k++) cyc(sw, 1'b1);
  endtask

  initial begin
    bus.i_Switch = '0;
    i_Rst_L      = 1'b0;

    // reset while switches toggle
    for (int k = 0; k < 3; k++) begin
      cyc((k % 2) ? 4'b1111 : 4'b0000, 1'b0);
      chk("rst_led", {4'b0, bus.o_LED}, 8'h00);
      chk("rst_mode", {6'b0, bus.o_Mode}, 8'h00);
    end

    // latency: LED follows 7 edges after the change
    hold(4'b0101, 6);
    chk("lat_pre", {4'b0, bus.o_LED}, 8'h00);
    hold(4'b0101, 1);
    chk("lat_hit", {4'b0, bus.o_LED}, 8'h01);

`ifndef SEQ_AUTO_CYCLE_EN
    // short glitch on switch 0 must not pass
    cyc(4'b0000, 1'b0);
    hold(4'b0100, 10);
    for (int k = 0; k < 3; k++) cyc(4'b0101, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cyc(4'b0100, 1'b1);
      chk("glitch", {4'b0, bus.o_LED}, 8'h00);
    end

    // chord steps once, OR pattern, re-chord
    hold(4'b1111, 100);
    chk("chord_hold", {6'b0, bus.o_Mode}, 8'h01);
    hold(4'b1000, 10);
    chk("or_led", {4'b0, bus.o_LED}, 8'h0A);
    hold(4'b1111, 10);
    chk("rechord", {6'b0, bus.o_Mode}, 8'h02);

    // wrap through NAND
    cyc(4'b0000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      hold(4'b1111, 10);
      hold(4'b0000, 10);
    end
    chk("nand_mode", {6'b0, bus.o_Mode}, 8'h03);
    chk("nand_led", {4'b0, bus.o_LED}, 8'h0F);
    hold(4'b1111, 10);
    chk("wrap_mode", {6'b0, bus.o_Mode}, 8'h00);

    // reset mid-debounce
    hold(4'b0101, 3);
    cyc(4'b0101, 1'b0);
    chk("mid_rst_led", {4'b0, bus.o_LED}, 8'h00);
    chk("mid_rst_mode", {6'b0, bus.o_Mode}, 8'h00);

    // no timer: mode holds
    hold(4'b0000, 100);
    chk("no_auto", {6'b0, bus.o_Mode}, 8'h00);
`else
    // timer steps every PERIOD cycles
    cyc(4'b0000, 1'b0);
    hold(4'b0000, PERIOD - 1);
    chk("auto_pre", {6'b0, bus.o_Mode}, 8'h00);
    hold(4'b0000, 1);
    chk("auto_1", {6'b0, bus.o_Mode}, 8'h01);
    hold(4'b0000, PERIOD);
    chk("auto_2", {6'b0, bus.o_Mode}, 8'h02);

    // chord landing on the expiry edge counts once
    cyc(4'b0000, 1'b0);
    hold(4'b0000, 3);
    hold(4'b1111, 7);
    chk("coinc", {6'b0, bus.o_Mode}, 8'h01);
    hold(4'b1111, PERIOD - 1);
    chk("coinc_hold", {6'b0, bus.o_Mode}, 8'h01);
    hold(4'b1111, 1);
    chk("coinc_next", {6'b0, bus.o_Mode}, 8'h02);

    // reset at cycle 5 restarts the period
    cyc(4'b0000, 1'b0);
    hold(4'b0000, 4);
    cyc(4'b0000, 1'b0);
    hold(4'b0000, PERIOD - 1);
    chk("rst5_pre", {6'b0, bus.o_Mode}, 8'h00);
    hold(4'b0000, 1);
    chk("rst5_step", {6'b0, bus.o_Mode}, 8'h01);
`endif

    // random traffic, chords and occasional resets
    for (int n = 0; n < 400; n++) begin
      logic [3:0] sw;
      int         len;
      sw  = 4'($urandom);
      if ($urandom_range(3) == 0) sw = 4'b1111;
      len = $urandom_range(1, 8);
      if ($urandom_range(40) == 0) cyc(sw, 1'b0);
      else                         hold(sw, len);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
